inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch stage of the multi-cycle CPU, directly upstream of the synchronous instruction ROM. It owns the PC, drives the ROM word address, and absorbs the ROM's one-cycle read latency. It latches the returned word into an instruction register and holds it with a valid flag until control acknowledges it. On acknowledge it selects the next PC (sequential or jump/branch target) and starts the next fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
ADDR_W, 8, width of ROM word address (rom_addr = pc[ADDR_W+1:2])
ROM_WORDS, 50, number of populated ROM words; used only for the out-of-range flag

Ports:
clk  in  1  system clock, all state on posedge
resetn  in  1  synchronous active-low reset
rom_addr  out  ADDR_W  word address to instruction ROM, = pc[ADDR_W+1:2], combinational from pc register
rom_inst  in  32  ROM read data, valid the cycle after rom_addr is sampled
inst_ack  in  1  control/decode consumed current instruction, request next fetch
jbr_taken  in  1  qualifies jbr_target; sampled only with inst_ack
jbr_target  in  32  next PC for taken jump/branch/jr
inst  out  32  instruction register
inst_pc  out  32  PC of the instruction held in inst
pc_plus4  out  32  inst_pc + 4 (for jal link, branch base)
inst_valid  out  1  inst/inst_pc hold a fetched instruction
fetch_err  out  1  sticky: fetched PC beyond ROM_WORDS*4-4 or above the ADDR_W address range

Behaviour:
- Synchronous reset (resetn=0 at posedge):
  - pc<=RESET_PC, state<=FETCH.
  - inst<=0, inst_pc<=0, inst_valid<=0, fetch_err<=0.
  - Reset wins over every other input, including mid-fetch or while VALID; an in-flight ROM read is discarded.
- FSM, three states:
  - FETCH: rom_addr presents pc; the ROM samples it at the edge. Next state LATCH.
  - LATCH:
    - inst<=rom_inst, inst_pc<=pc, pc<=pc+4, inst_valid<=1.
    - fetch_err<=fetch_err | (pc>>2 >= ROM_WORDS) | (pc[31:ADDR_W+2]!=0).
    - Next state VALID.
  - VALID: hold inst, inst_pc, inst_valid. On inst_ack=1:
    - pc<=jbr_taken ? {jbr_target[31:2],2'b00} : pc (already pc+4).
    - inst_valid<=0, next state FETCH.
    - Without inst_ack, stay indefinitely.
- inst_ack and jbr_taken are ignored outside VALID.
- jbr_taken without inst_ack has no effect.
- Target low 2 bits are forced to 0; there is no misalignment trap.
- Latency:
  - inst_valid rises 2 edges after resetn goes high.
  - Ack-to-next-valid is 3 edges: inst_valid low for exactly 2 cycles between instructions.
  - An inst_ack held constantly high gives one instruction per 3 cycles.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- rom_addr takes the pc bits only; upper bits are truncated (aliasing), and fetch_err flags it.
- fetch_err does not stop fetching; it clears only on reset.
- pc_plus4 = inst_pc + 4, combinational from inst_pc.
- Unused state encoding recovers to FETCH.

Decomposition:
- Shared cpu package holds:
  - fetch state enum (FETCH, LATCH, VALID; 2-bit)
  - PC_INC = 32'd4
  - RESET_PC default
  - ADDR_W / ROM_WORDS constants, common with the instruction ROM
- No sub-module; next-PC mux and FSM fit in one module.
- Bench instantiates the team's instruction ROM as the rom_inst source.

Test Plan:
- Reset release, inst_ack=0 -> rom_addr=0, after 2 edges inst_valid=1, inst=32'h3c010000, inst_pc=0, pc_plus4=4; stays held for 10 idle cycles.
- Sequential acks (jbr_taken=0) x3 -> inst_pc 0x04, 0x08, 0x0C; inst 34240000, 24050004, 0c000018; inst_valid low exactly 2 cycles each time.
- At inst_pc=0x0C: ack with jbr_taken=1, jbr_target=0x60 -> inst_pc=0x60, inst=00004021; target 0x63 also yields 0x60.
- jbr_taken=1 asserted in VALID without inst_ack, then ack with jbr_taken=0 -> sequential PC, target ignored.
- Pulse resetn=0 during LATCH and during VALID -> next cycle inst_valid=0, pc=RESET_PC, first fetch restarts at 0 with normal 2-edge latency.
- Jump target 0xC8 (word 50) -> fetch_err=1 after that LATCH; target 0x400 -> rom_addr=0 (alias), fetch_err=1; subsequent jump to 0x00 keeps fetch_err=1 until reset.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions for the fetch stage and the instruction ROM.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam int          DEF_ADDR_W    = 8;
  localparam int          DEF_ROM_WORDS = 50;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM address/data plus the instruction handshake with control.
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              inst_ack;
  logic              jbr_taken;
  logic [31:0]       jbr_target;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic [31:0]       pc_plus4;
  logic              inst_valid;
  logic              fetch_err;

  modport master (
    output rom_addr, inst, inst_pc, pc_plus4, inst_valid, fetch_err,
    input  rom_inst, inst_ack, jbr_taken, jbr_target
  );

  modport slave (
    input  rom_addr, inst, inst_pc, pc_plus4, inst_valid, fetch_err,
    output rom_inst, inst_ack, jbr_taken, jbr_target
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, absorbs the one-cycle ROM latency and
// holds the fetched word until control acknowledges it.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          ROM_WORDS = DEF_ROM_WORDS
) (
  input  logic         clk,
  input  logic         resetn,
  inst_fetch_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;
  logic         inst_valid_q;
  logic         fetch_err_q;
  logic         pc_out_of_range;

  // Upper pc bits are dropped from the ROM address, so aliasing is flagged here.
  assign pc_out_of_range = ((pc >> 2) >= 32'(ROM_WORDS)) || (pc[31:ADDR_W+2] != '0);

  assign bus.rom_addr   = pc[ADDR_W+1:2];
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc_plus4   = inst_pc_q + PC_INC;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fetch_err  = fetch_err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= LATCH;
        LATCH: begin
          inst_q       <= bus.rom_inst;
          inst_pc_q    <= pc;
          pc           <= pc + PC_INC;
          inst_valid_q <= 1'b1;
          fetch_err_q  <= fetch_err_q | pc_out_of_range;
          state        <= VALID;
        end
        VALID: begin
          // pc already points past the held instruction; only a taken jump overrides it.
          if (bus.inst_ack) begin
            if (bus.jbr_taken) begin
              pc <= {bus.jbr_target[31:2], 2'b00};
            end
            inst_valid_q <= 1'b0;
            state        <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a transaction-level fetch model plus directed vectors.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int WORDS = DEF_ROM_WORDS;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(AW)) bus ();

  inst_fetch #(.RESET_PC(32'h0), .ADDR_W(AW), .ROM_WORDS(WORDS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Synchronous instruction ROM, one-cycle read latency.
  logic [31:0] rom_mem [0:(1<<AW)-1];
  logic [31:0] rom_q;

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      rom_mem[i] = (i < WORDS) ? 32'h2000_0000 + 32'(i) : 32'hBAD0_0000 + 32'(i);
    rom_mem[0]  = 32'h3c01_0000;
    rom_mem[1]  = 32'h3424_0000;
    rom_mem[2]  = 32'h2405_0004;
    rom_mem[3]  = 32'h0c00_0018;
    rom_mem[24] = 32'h0000_4021;
  end

  always @(posedge clk) rom_q <= rom_mem[bus.rom_addr];
  assign bus.rom_inst = rom_q;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after reset or an ack, the next instruction becomes valid two edges later.
  bit          model_live = 0;
  bit          m_valid;
  bit          m_err;
  int          m_delay;
  logic [31:0] m_next;
  logic [31:0] m_inst;
  logic [31:0] m_inst_pc;

  always @(posedge clk) begin
    if (!resetn) begin
      model_live = 1;
      m_valid    = 0;
      m_err      = 0;
      m_delay    = 2;
      m_next     = 32'h0;
      m_inst     = 32'h0;
      m_inst_pc  = 32'h0;
    end else if (model_live) begin
      if (m_valid) begin
        if (bus.inst_ack) begin
          m_valid = 0;
          m_next  = bus.jbr_taken ? (bus.jbr_target & 32'hFFFF_FFFC) : m_inst_pc + 32'd4;
          m_delay = 2;
        end
      end else begin
        m_delay--;
        if (m_delay == 0) begin
          m_valid   = 1;
          m_inst_pc = m_next;
          m_inst    = rom_mem[(m_next >> 2) % (1 << AW)];
          m_err     = m_err || (m_next >= 32'(WORDS * 4)) || (m_next >= 32'(1 << (AW + 2)));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      logic [31:0] exp_addr;
      exp_addr = m_valid ? ((m_inst_pc + 32'd4) >> 2) % (1 << AW) : (m_next >> 2) % (1 << AW);
      checkOutput("model_valid", 32'(bus.inst_valid), 32'(m_valid));
      checkOutput("model_fetch_err", 32'(bus.fetch_err), 32'(m_err));
      checkOutput("model_rom_addr", 32'(bus.rom_addr), exp_addr);
      if (m_valid) begin
        checkOutput("model_inst", bus.inst, m_inst);
        checkOutput("model_inst_pc", bus.inst_pc, m_inst_pc);
        checkOutput("model_pc_plus4", bus.pc_plus4, m_inst_pc + 32'd4);
      end
    end
  end

  task automatic applyStimulus(input bit ack, input bit taken, input logic [31:0] target);
    bus.inst_ack   = ack;
    bus.jbr_taken  = taken;
    bus.jbr_target = target;
  endtask

  task automatic countUntilValid(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.inst_valid && edges < 20);
  endtask

  task automatic ackAndWait(input bit taken, input logic [31:0] target, output int edges);
    int n;
    applyStimulus(1'b1, taken, target);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    countUntilValid(n);
    edges = 1 + n;
  endtask

  logic [31:0] seq_pc   [3] = '{32'h04, 32'h08, 32'h0C};
  logic [31:0] seq_inst [3] = '{32'h3424_0000, 32'h2405_0004, 32'h0c00_0018};

  initial begin
    int n;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("reset_inst", bus.inst, 32'h0);
    checkOutput("reset_inst_pc", bus.inst_pc, 32'h0);
    checkOutput("reset_err", 32'(bus.fetch_err), 32'd0);
    checkOutput("reset_rom_addr", 32'(bus.rom_addr), 32'd0);

    resetn = 1'b1;
    countUntilValid(n);
    checkOutput("first_latency", 32'(n), 32'd2);
    checkOutput("first_inst", bus.inst, 32'h3c01_0000);
    checkOutput("first_pc", bus.inst_pc, 32'h0);
    checkOutput("first_plus4", bus.pc_plus4, 32'h4);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("idle_inst", bus.inst, 32'h3c01_0000);

    for (int i = 0; i < 3; i++) begin
      ackAndWait(1'b0, 32'h0, n);
      checkOutput("seq_gap", 32'(n), 32'd3);
      checkOutput("seq_pc", bus.inst_pc, seq_pc[i]);
      checkOutput("seq_inst", bus.inst, seq_inst[i]);
    end

    ackAndWait(1'b1, 32'h60, n);
    checkOutput("jump_pc", bus.inst_pc, 32'h60);
    checkOutput("jump_inst", bus.inst, 32'h0000_4021);
    ackAndWait(1'b1, 32'h63, n);
    checkOutput("jump_unaligned_pc", bus.inst_pc, 32'h60);

    applyStimulus(1'b0, 1'b1, 32'h80);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("taken_no_ack_pc", bus.inst_pc, 32'h60);
    ackAndWait(1'b0, 32'h80, n);
    checkOutput("taken_ignored_pc", bus.inst_pc, 32'h64);

    // Reset landing in LATCH: ack edge -> FETCH, next edge -> LATCH.
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_latch_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst_latch_addr", 32'(bus.rom_addr), 32'd0);
    resetn = 1'b1;
    countUntilValid(n);
    checkOutput("rst_latch_latency", 32'(n), 32'd2);
    checkOutput("rst_latch_pc", bus.inst_pc, 32'h0);

    resetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_valid_valid", 32'(bus.inst_valid), 32'd0);
    resetn = 1'b1;
    countUntilValid(n);
    checkOutput("rst_valid_latency", 32'(n), 32'd2);
    checkOutput("rst_valid_inst", bus.inst, 32'h3c01_0000);

    ackAndWait(1'b1, 32'hC8, n);
    checkOutput("oob_pc", bus.inst_pc, 32'hC8);
    checkOutput("oob_err", 32'(bus.fetch_err), 32'd1);

    applyStimulus(1'b1, 1'b1, 32'h400);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("alias_rom_addr", 32'(bus.rom_addr), 32'd0);
    countUntilValid(n);
    checkOutput("alias_pc", bus.inst_pc, 32'h400);
    checkOutput("alias_inst", bus.inst, 32'h3c01_0000);

    ackAndWait(1'b1, 32'h0, n);
    checkOutput("sticky_pc", bus.inst_pc, 32'h0);
    checkOutput("sticky_err", 32'(bus.fetch_err), 32'd1);

    resetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("err_cleared", 32'(bus.fetch_err), 32'd0);
    resetn = 1'b1;
    countUntilValid(n);
    checkOutput("final_latency", 32'(n), 32'd2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
